// File: rtl/dec_2to4_pipe.sv
// ============================================================================
//  Module      : dec_2to4_pipe
//  Description : Registered binary-to-one-hot decoder with a valid/ready input
//                and a 2-entry skid buffer on the output. Optional even-parity
//                check on the input code is enabled by DEC_PARITY_CHK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_2to4_pipe #(
  parameter int IN_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IN_W-1:0]        in,
  input  logic                   in_en,
`ifdef DEC_PARITY_CHK_EN
  input  logic                   in_par,
  output logic                   par_err,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [(1<<IN_W)-1:0]   out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CNT_W-1:0]       dec_cnt,
  output logic                   dis_seen
);

  localparam int c_out_w = 1 << IN_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_out_w-1:0]   r_main;
  logic [c_out_w-1:0]   r_skid;
  logic                 r_out_valid;
  logic                 r_in_ready;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_dis_seen;
  logic                 w_acc;
  logic                 w_dlv;
  logic                 w_bad_par;
  logic [c_out_w-1:0]   w_word;

  assign w_acc = in_valid & r_in_ready;
  assign w_dlv = r_out_valid & out_ready;

`ifdef DEC_PARITY_CHK_EN
  logic r_par_err;
  assign w_bad_par = ^{in, in_par};
  assign par_err   = r_par_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_par_err <= 1'b0;
    else if (w_acc && w_bad_par)
      r_par_err <= 1'b1;
  end
`else
  assign w_bad_par = 1'b0;
`endif

  // A bad-parity code still occupies a slot, but carries an all-zero word.
  assign w_word = (in_en && !w_bad_par) ? (c_out_w'(1) << in) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_cnt       <= '0;
      r_dis_seen  <= 1'b0;
    end else begin
      if (w_dlv)
        r_cnt <= r_cnt + 1'b1;
      if (w_acc && !in_en)
        r_dis_seen <= 1'b1;

      case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            r_main      <= w_word;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_acc && w_dlv) begin
            r_main <= w_word;
          end else if (w_acc) begin
            r_skid     <= w_word;
            r_in_ready <= 1'b0;
            r_state    <= ST_TWO;
          end else if (w_dlv) begin
            r_main      <= '0;
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_dlv) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_main      <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out       = r_main;
  assign out_valid = r_out_valid;
  assign dec_cnt   = r_cnt;
  assign dis_seen  = r_dis_seen;

endmodule

`default_nettype wire

// File: tb/tb_dec_2to4_pipe.sv
// Directed bench for dec_2to4_pipe with a queue scoreboard of expected words.
`default_nettype none

module tb_dec_2to4_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in;
  logic       in_en;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] dec_cnt;
  logic       dis_seen;
  logic       in_par;
  logic       par_bad;
`ifdef DEC_PARITY_CHK_EN
  logic       par_err;
`endif

  dec_2to4_pipe #(.IN_W(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_en     (in_en),
`ifdef DEC_PARITY_CHK_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dec_cnt   (dec_cnt),
    .dis_seen  (dis_seen)
  );

  always #5 clk = ~clk;

  logic [3:0] q[$];
  logic [3:0] cnt_m;
  logic       dis_m;
  logic       last_acc;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock of stimulus: compare against the model, then advance the model.
  task automatic cyc(input logic v, input logic [1:0] c, input logic en, input logic ordy);
    logic [3:0] w;
    logic [3:0] e;
    in_valid = v; in = c; in_en = en; out_ready = ordy;
    in_par = (^c) ^ par_bad;
    #1;
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("dec_cnt", dec_cnt, cnt_m);
    chk("dis_seen", dis_seen, dis_m);
    last_acc = in_valid && in_ready;
    if (out_valid && out_ready) begin
      e = (q.size() > 0) ? q.pop_front() : 4'hx;
      chk("out", out, e);
      cnt_m = cnt_m + 4'd1;
    end
    if (last_acc) begin
      w = en ? (4'b0001 << c) : 4'b0000;
`ifdef DEC_PARITY_CHK_EN
      if (^{c, in_par}) w = 4'b0000;
`endif
      q.push_back(w);
      if (!en) dis_m = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] c, input logic en, input logic ordy);
    int k = 0;
    do begin
      cyc(1'b1, c, en, ordy);
      k++;
    end while (!last_acc && k < 10);
    if (!last_acc) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 10) begin
      cyc(1'b0, 2'd0, 1'b1, 1'b1);
      k++;
    end
    if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; in_valid = 1'b0;
    q.delete(); cnt_m = '0; dis_m = 1'b0;
    chk("rst_out", out, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_dec_cnt", dec_cnt, 4'd0);
    chk("rst_dis_seen", dis_seen, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in = '0; in_en = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_par = 1'b0; par_bad = 1'b0;
    cnt_m = '0; dis_m = 1'b0; last_acc = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // Sweep: back-to-back codes with the sink always ready
    for (int i = 0; i < 4; i++) send(2'(i), 1'b1, 1'b1);
    drain();
    chk("sweep_dec_cnt", dec_cnt, 4'd4);

    // Stall: third code must wait until the buffer frees up
    send(2'd2, 1'b1, 1'b0);
    send(2'd1, 1'b1, 1'b0);
    cyc(1'b1, 2'd3, 1'b1, 1'b0);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_out", out, 4'b0100);
    send(2'd3, 1'b1, 1'b1);
    drain();
    chk("stall_dec_cnt", dec_cnt, 4'd7);

    // Disable: word is zero and the sticky flag rises
    send(2'd3, 1'b0, 1'b1);
    drain();
    chk("dis_flag", dis_seen, 1'b1);
    send(2'd1, 1'b1, 1'b1);
    drain();
    chk("dis_sticky", dis_seen, 1'b1);

`ifdef DEC_PARITY_CHK_EN
    par_bad = 1'b1;
    send(2'd2, 1'b1, 1'b1);
    par_bad = 1'b0;
    drain();
    chk("par_err_set", par_err, 1'b1);
    cyc(1'b1, 2'd3, 1'b1, 1'b1);
    in_par = 1'b0;
    drain();
    chk("par_err_sticky", par_err, 1'b1);
`endif

    // Mid-traffic reset with both buffer slots full
    send(2'd0, 1'b1, 1'b0);
    send(2'd2, 1'b1, 1'b0);
    chk("pre_rst_in_ready", in_ready, 1'b0);
    do_reset();

    // Counter wrap on a 4-bit counter
    for (int i = 0; i < 17; i++) send(2'(i % 4), 1'b1, 1'b1);
    drain();
    chk("wrap_dec_cnt", dec_cnt, 4'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
